// File: rtl/prbs_gen.sv
// prbs_gen: Fibonacci-LFSR PRBS generator emitting NB_OUT serial bits per enabled cycle,
// with runtime seed load, error injection and period-wrap flag.
module prbs_gen #(
  parameter int ORDER = 9,
  parameter int NB_OUT = 1,
  parameter logic [ORDER-1:0] SEED = 9'h1AA
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_load,
  input  logic [ORDER-1:0]  i_seed,
  input  logic              i_inject_err,
  output logic [NB_OUT-1:0] o_data,
  output logic              o_valid,
  output logic              o_wrap
);
  localparam int TAP = ORDER == 7 ? 6 : ORDER == 9 ? 5 : ORDER == 15 ? 14 : ORDER == 23 ? 18 : 28;
  localparam logic [ORDER-1:0] INIT = (SEED == '0) ? '1 : SEED;
  localparam logic [ORDER:0] P = {1'b0, {ORDER{1'b1}}};
  logic [ORDER-1:0]  lfsr, lfsr_nxt, seed_fix, cnt;
  logic [ORDER:0]    sum;
  logic [NB_OUT-1:0] bits;
  logic              wrap_nxt;
  always_comb begin
    lfsr_nxt = lfsr;
    bits = '0;
    for (int i = 0; i < NB_OUT; i++) begin
      bits[NB_OUT-1-i] = lfsr_nxt[ORDER-1];
      lfsr_nxt = {lfsr_nxt[ORDER-2:0], lfsr_nxt[ORDER-1] ^ lfsr_nxt[TAP-1]};
    end
  end
  // the word spans counter values cnt .. cnt+NB_OUT-1 (mod P); it holds 0 if it starts there or crosses P
  assign sum      = {1'b0, cnt} + (ORDER+1)'(NB_OUT);
  assign wrap_nxt = (cnt == '0) || (sum > P);
  assign seed_fix = (i_seed == '0) ? '1 : i_seed;
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      lfsr    <= INIT;
      cnt     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else if (i_load) begin
      lfsr    <= seed_fix;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else if (i_enable) begin
      lfsr    <= lfsr_nxt;
      cnt     <= (sum >= P) ? ORDER'(sum - P) : sum[ORDER-1:0];
      o_data  <= bits ^ (NB_OUT'(i_inject_err) << (NB_OUT-1));
      o_valid <= 1'b1;
      o_wrap  <= wrap_nxt;
    end else begin
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prbs_gen.sv
// tb_prbs_gen: directed bench for prbs_gen, a 1-bit and an 8-bit instance side by side
// against a recurrence-based golden bit stream.
module tb_prbs_gen;
  logic       clock = 1'b0;
  logic       i_reset = 1'b0, i_enable = 1'b0, i_load = 1'b0, i_inject_err = 1'b0;
  logic [8:0] i_seed = '0;
  logic       d1, v1, w1, v8, w8;
  logic [7:0] d8;
  int         checks = 0, passes = 0;
  bit         g [511];

  always #5 clock = ~clock;

  prbs_gen #(.ORDER(9), .NB_OUT(1), .SEED(9'h1AA)) dut1 (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_load(i_load),
    .i_seed(i_seed), .i_inject_err(i_inject_err), .o_data(d1), .o_valid(v1), .o_wrap(w1));
  prbs_gen #(.ORDER(9), .NB_OUT(8), .SEED(9'h1AA)) dut8 (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_load(i_load),
    .i_seed(i_seed), .i_inject_err(i_inject_err), .o_data(d8), .o_valid(v8), .o_wrap(w8));

  // serial stream a(n+9) = a(n) ^ a(n+4), first nine bits are the seed MSB first
  function automatic void gen(input logic [8:0] seed);
    for (int k = 0; k < 9; k++) g[k] = seed[8-k];
    for (int n = 9; n < 511; n++) g[n] = g[n-9] ^ g[n-5];
  endfunction
  function automatic bit gb(input int n);
    return g[n % 511];
  endfunction
  function automatic logic [7:0] gw(input int k);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[7-j] = gb(8*(k-1) + j);
    return w;
  endfunction
  function automatic bit gwrap8(input int k);
    bit r = 0;
    for (int j = 0; j < 8; j++) if ((8*(k-1) + j) % 511 == 0) r = 1;
    return r;
  endfunction

  task automatic do_reset();
    i_reset = 1; i_enable = 0; i_load = 0; i_inject_err = 0;
    @(posedge clock); #1;
    i_reset = 0;
  endtask

  task automatic test_reset();
    #1 i_reset = 1;
    #2;
    checks++;
    if ({d1, v1, w1} !== 3'b0) $display("FAIL reset_dut1 got %b want 000", {d1, v1, w1});
    else passes++;
    checks++;
    if ({d8, v8, w8} !== 10'b0) $display("FAIL reset_dut8 got %h want 000", {d8, v8, w8});
    else passes++;
    @(posedge clock); #1;
    i_reset = 0;
  endtask

  task automatic test_sequence();
    gen(9'h1AA);
    do_reset();
    i_enable = 1;
    for (int k = 1; k <= 1022; k++) begin
      @(posedge clock); #1;
      checks++;
      if ({v1, w1, d1} !== {1'b1, (k-1) % 511 == 0, gb(k-1)})
        $display("FAIL seq1 word %0d got %b want %b", k, {v1, w1, d1}, {1'b1, (k-1) % 511 == 0, gb(k-1)});
      else passes++;
      checks++;
      if ({v8, w8, d8} !== {1'b1, gwrap8(k), gw(k)})
        $display("FAIL seq8 word %0d got %h want %h", k, {v8, w8, d8}, {1'b1, gwrap8(k), gw(k)});
      else passes++;
    end
    i_enable = 0;
  endtask

  task automatic test_load_ones();
    logic [14:0] ones = 15'b111111111000001;
    gen(9'h1AA);
    do_reset();
    i_enable = 1;
    repeat (5) @(posedge clock);
    #1 i_enable = 0;
    @(posedge clock); #1;
    checks++;
    if ({v1, w1, d1, v8, w8, d8} !== {2'b00, gb(4), 2'b00, gw(5)})
      $display("FAIL hold got %h want %h", {v1, w1, d1, v8, w8, d8}, {2'b00, gb(4), 2'b00, gw(5)});
    else passes++;
    i_load = 1; i_seed = 9'h1FF;
    @(posedge clock); #1;
    checks++;
    if ({v1, w1, d1, v8, w8, d8} !== {2'b00, gb(4), 2'b00, gw(5)})
      $display("FAIL load_hold got %h want %h", {v1, w1, d1, v8, w8, d8}, {2'b00, gb(4), 2'b00, gw(5)});
    else passes++;
    i_load = 0; i_enable = 1;
    gen(9'h1FF);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clock); #1;
      checks++;
      if ({v1, w1, d1} !== {1'b1, k == 1, ones[15-k]})
        $display("FAIL ones1 bit %0d got %b want %b", k, {v1, w1, d1}, {1'b1, k == 1, ones[15-k]});
      else passes++;
      checks++;
      if ({v8, w8, d8} !== {1'b1, k == 1, gw(k)})
        $display("FAIL ones8 word %0d got %h want %h", k, {v8, w8, d8}, {1'b1, k == 1, gw(k)});
      else passes++;
    end
  endtask

  task automatic test_load_zero();
    logic       p1 = d1;
    logic [7:0] p8 = d8;
    i_load = 1; i_seed = 9'h000; i_enable = 1;
    @(posedge clock); #1;
    checks++;
    if ({v1, w1, d1, v8, w8, d8} !== {2'b00, p1, 2'b00, p8})
      $display("FAIL load_zero got %h want %h", {v1, w1, d1, v8, w8, d8}, {2'b00, p1, 2'b00, p8});
    else passes++;
    i_load = 0;
    gen(9'h1FF);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      checks++;
      if ({v1, w1, d1} !== {1'b1, k == 1, gb(k-1)})
        $display("FAIL zero1 word %0d got %b want %b", k, {v1, w1, d1}, {1'b1, k == 1, gb(k-1)});
      else passes++;
      checks++;
      if ({v8, w8, d8} !== {1'b1, k == 1, gw(k)})
        $display("FAIL zero8 word %0d got %h want %h", k, {v8, w8, d8}, {1'b1, k == 1, gw(k)});
      else passes++;
    end
    i_enable = 0;
  endtask

  task automatic test_inject();
    gen(9'h1AA);
    do_reset();
    i_enable = 1;
    for (int k = 1; k <= 30; k++) begin
      i_inject_err = (k == 20);
      @(posedge clock); #1;
      checks++;
      if (d1 !== (gb(k-1) ^ (k == 20)))
        $display("FAIL inj1 word %0d got %b want %b", k, d1, gb(k-1) ^ (k == 20));
      else passes++;
      checks++;
      if (d8 !== (gw(k) ^ {k == 20, 7'b0}))
        $display("FAIL inj8 word %0d got %h want %h", k, d8, gw(k) ^ {k == 20, 7'b0});
      else passes++;
    end
    i_inject_err = 0; i_enable = 0;
  endtask

  task automatic test_async_reset();
    gen(9'h1AA);
    do_reset();
    i_enable = 1;
    repeat (300) @(posedge clock);
    #1;
    checks++;
    if ({v1, v8} !== 2'b11) $display("FAIL pre_abort_valid got %b want 11", {v1, v8});
    else passes++;
    #2 i_reset = 1;
    #1;
    checks++;
    if ({d1, v1, w1, d8, v8, w8} !== 13'b0)
      $display("FAIL async_reset got %h want 0", {d1, v1, w1, d8, v8, w8});
    else passes++;
    #2 i_reset = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      checks++;
      if ({v1, w1, d1} !== {1'b1, k == 1, gb(k-1)})
        $display("FAIL restart1 word %0d got %b want %b", k, {v1, w1, d1}, {1'b1, k == 1, gb(k-1)});
      else passes++;
      checks++;
      if ({v8, w8, d8} !== {1'b1, k == 1, gw(k)})
        $display("FAIL restart8 word %0d got %h want %h", k, {v8, w8, d8}, {1'b1, k == 1, gw(k)});
      else passes++;
    end
    i_enable = 0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_load_ones();
    test_load_zero();
    test_inject();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
